mc_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the miniLA datapath; replaces the single-cycle "every signal every cycle" timing with the FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequence.
- Classifies the latched instruction and gates the existing decoder's write enables (PC, IR, register file, RAM) so each one fires only in the correct phase.
- Owns the req/ack handshakes to instruction and data memory, including timeout detection, a halt point and a retired-instruction counter.

---
 rtl/mc_pkg.sv | 49 ++++
 rtl/mc_inst_class.sv | 35 +++
 rtl/mc_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mc_seq_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the miniLA multi-cycle sequencer.
// Holds the state encoding, the opcode map and the fault codes.
package mc_pkg;

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5,
    StErr  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsWb,
    ClsIllegal
  } inst_class_e;

  localparam logic [5:0] OpAlu0 = 6'b000000;
  localparam logic [5:0] OpAlu1 = 6'b000101;
  localparam logic [5:0] OpAlu2 = 6'b000111;
  localparam logic [5:0] OpAlu3 = 6'b010011;
  localparam logic [5:0] OpAlu4 = 6'b010101;
  localparam logic [5:0] OpMem  = 6'b001010;
  localparam logic [5:0] OpBr0  = 6'b010110;
  localparam logic [5:0] OpBr1  = 6'b010111;
  localparam logic [5:0] OpBr2  = 6'b011000;
  localparam logic [5:0] OpBr3  = 6'b011001;
  localparam logic [5:0] OpBr4  = 6'b011010;
  localparam logic [5:0] OpBr5  = 6'b011011;
  localparam logic [5:0] OpBr6  = 6'b010100;

  localparam logic [2:0] F3LdB = 3'b000;
  localparam logic [2:0] F3LdH = 3'b001;
  localparam logic [2:0] F3LdW = 3'b010;
  localparam logic [2:0] F3StB = 3'b100;
  localparam logic [2:0] F3StH = 3'b101;
  localparam logic [2:0] F3StW = 3'b110;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrImem    = 2'b01;
  localparam logic [1:0] ErrDmem    = 2'b10;
  localparam logic [1:0] ErrIllegal = 2'b11;

endpackage

// File: rtl/mc_inst_class.sv
// Combinational instruction classifier: maps the upper IR bits onto the
// sequencing class that decides which phases an instruction walks through.
module mc_inst_class
  import mc_pkg::*;
(
  input  logic [16:0] i_inst_hi,
  output inst_class_e o_class
);

  logic [5:0] w_op;
  logic [2:0] w_func3;
  logic       w_unused;

  assign w_op     = i_inst_hi[16:11];
  assign w_func3  = i_inst_hi[9:7];
  // sig and func7 only matter to the datapath decoder, not to sequencing
  assign w_unused = ^{i_inst_hi[10], i_inst_hi[6:0]};

  always_comb begin
    o_class = ClsIllegal;
    case (w_op)
      OpMem: begin
        case (w_func3)
          F3LdB, F3LdH, F3LdW: o_class = ClsLoad;
          F3StB, F3StH, F3StW: o_class = ClsStore;
          default:             o_class = ClsIllegal;
        endcase
      end
      OpBr0, OpBr1, OpBr2, OpBr3, OpBr4, OpBr5, OpBr6: o_class = ClsBranch;
      OpAlu0, OpAlu1, OpAlu2, OpAlu3, OpAlu4:          o_class = ClsWb;
      default:                                         o_class = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle sequencer for the miniLA datapath: walks IF/ID/EX/MEM/WB, gates
// the decoder write strobes per phase and owns the memory req/ack handshakes.
module mc_seq_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [16:0]      i_inst_hi,
  output logic             o_imem_req,
  input  logic             i_imem_ack,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  input  logic             i_dmem_ack,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic             o_rf_we,
  input  logic             i_halt_req,
  output logic             o_halted,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_retire_cnt,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic [2:0]       o_state
);

  localparam int unsigned     TmoW   = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(ACK_TIMEOUT);

  state_e           r_state, w_state_d;
  logic [TmoW-1:0]  r_tmo, w_tmo_d;
  logic             r_err, w_err_d;
  logic [1:0]       r_err_code, w_err_code_d;
  logic [CNT_W-1:0] r_retire_cnt;

  inst_class_e w_class;
  state_e      w_next_done;
  logic        w_tmo_inc;
  logic        w_ir_we, w_pc_we, w_rf_we, w_retire;

  mc_inst_class u_inst_class (
    .i_inst_hi (i_inst_hi),
    .o_class   (w_class)
  );

  always_comb begin
    w_state_d    = r_state;
    w_err_d      = r_err;
    w_err_code_d = r_err_code;
    w_tmo_inc    = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_rf_we      = 1'b0;
    w_retire     = 1'b0;
    w_next_done  = i_halt_req ? StHalt : StIf;

    case (r_state)
      StIf: begin
        if (i_imem_ack) begin
          w_ir_we   = 1'b1;
          w_state_d = StId;
        end else if (r_tmo == TmoMax) begin
          w_state_d    = StErr;
          w_err_d      = 1'b1;
          w_err_code_d = ErrImem;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end
      StId: w_state_d = StEx;
      StEx: begin
        case (w_class)
          ClsLoad, ClsStore: w_state_d = StMem;
          ClsWb:             w_state_d = StWb;
          ClsBranch: begin
            w_pc_we   = 1'b1;
            w_retire  = 1'b1;
            w_state_d = w_next_done;
          end
          default: begin
            w_state_d    = StErr;
            w_err_d      = 1'b1;
            w_err_code_d = ErrIllegal;
          end
        endcase
      end
      StMem: begin
        if (i_dmem_ack) begin
          if (w_class == ClsStore) begin
            w_pc_we   = 1'b1;
            w_retire  = 1'b1;
            w_state_d = w_next_done;
          end else begin
            w_state_d = StWb;
          end
        end else if (r_tmo == TmoMax) begin
          w_state_d    = StErr;
          w_err_d      = 1'b1;
          w_err_code_d = ErrDmem;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end
      StWb: begin
        w_rf_we   = 1'b1;
        w_pc_we   = 1'b1;
        w_retire  = 1'b1;
        w_state_d = w_next_done;
      end
      StHalt: begin
        if (!i_halt_req) w_state_d = StIf;
      end
      StErr:   w_state_d = StErr;
      default: w_state_d = StErr;
    endcase

    // Any state change restarts the wait count, so IF and MEM start from zero
    if (w_state_d != r_state) begin
      w_tmo_d = '0;
    end else if (w_tmo_inc) begin
      w_tmo_d = r_tmo + TmoW'(1);
    end else begin
      w_tmo_d = r_tmo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIf;
      r_tmo        <= '0;
      r_err        <= 1'b0;
      r_err_code   <= ErrNone;
      r_retire_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_tmo      <= w_tmo_d;
      r_err      <= w_err_d;
      r_err_code <= w_err_code_d;
      if (w_retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  // Reset forces state to IF, so requests are qualified by rst_n to stay quiet
  always_comb begin
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_halted   = 1'b0;
    o_ir_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_rf_we    = 1'b0;
    o_retire   = 1'b0;
    if (rst_n) begin
      o_imem_req = (r_state == StIf);
      o_dmem_req = (r_state == StMem);
      o_dmem_we  = (r_state == StMem) && (w_class == ClsStore);
      o_halted   = (r_state == StHalt);
      o_ir_we    = w_ir_we;
      o_pc_we    = w_pc_we;
      o_rf_we    = w_rf_we;
      o_retire   = w_retire;
    end
  end

  assign o_state      = r_state;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;
  assign o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Self-checking bench for mc_seq_ctrl: a per-cycle vector table plus directed
// sequences for faults, reset mid-handshake and retire counter wrap.
module tb_mc_seq_ctrl;

  localparam logic [16:0] Add  = 17'b000000_0_000_0100000;
  localparam logic [16:0] Ldw  = 17'b001010_0_010_0000000;
  localparam logic [16:0] Stw  = 17'b001010_0_110_0000000;
  localparam logic [16:0] Beq  = 17'b010110_0_000_0000000;
  localparam logic [16:0] Ill  = 17'b111111_0_000_0000000;
  localparam logic [16:0] Ill2 = 17'b001010_0_011_0000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] inst_hi;
  logic        imem_ack, dmem_ack, halt_req;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halted, retire, err;
  logic [3:0]  retire_cnt;
  logic [1:0]  err_code;
  logic [2:0]  state;

  always #5 clk = ~clk;

  mc_seq_ctrl #(
    .ACK_TIMEOUT (4),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inst_hi    (inst_hi),
    .o_imem_req   (imem_req),
    .i_imem_ack   (imem_ack),
    .o_dmem_req   (dmem_req),
    .o_dmem_we    (dmem_we),
    .i_dmem_ack   (dmem_ack),
    .o_ir_we      (ir_we),
    .o_pc_we      (pc_we),
    .o_rf_we      (rf_we),
    .i_halt_req   (halt_req),
    .o_halted     (halted),
    .o_retire     (retire),
    .o_retire_cnt (retire_cnt),
    .o_err        (err),
    .o_err_code   (err_code),
    .o_state      (state)
  );

  // {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, halted, state, err, code, cnt}
  logic [17:0] got;
  assign got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, halted,
                state, err, err_code, retire_cnt};

  typedef struct {
    string       name;
    logic [16:0] inst;
    logic        ia;
    logic        da;
    logic        hr;
    logic [17:0] exp;
  } vec_t;

  vec_t       tbl[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] m_cnt = 4'd0;

  function automatic logic [17:0] ev(input logic [7:0] strb, input logic [2:0] st,
                                     input logic e, input logic [1:0] code,
                                     input logic [3:0] cnt);
    return {strb, st, e, code, cnt};
  endfunction

  task automatic check(input string nm, input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b", nm, got, exp);
    end
  endtask

  task automatic step(input string nm, input logic [16:0] inst, input logic ia,
                      input logic da, input logic hr, input logic [17:0] exp);
    inst_hi  = inst;
    imem_ack = ia;
    dmem_ack = da;
    halt_req = hr;
    @(negedge clk);
    check(nm, exp);
    @(posedge clk);
    #1;
  endtask

  // Expected retire count is tracked here and bumped after every retiring vector
  task automatic add(input string nm, input logic [16:0] inst, input logic ia, input logic da,
                     input logic hr, input logic [7:0] strb, input logic [2:0] st,
                     input logic e, input logic [1:0] code);
    vec_t v;
    v.name = nm;
    v.inst = inst;
    v.ia   = ia;
    v.da   = da;
    v.hr   = hr;
    v.exp  = ev(strb, st, e, code, m_cnt);
    tbl.push_back(v);
    if (strb[1]) m_cnt = m_cnt + 4'd1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    halt_req = 1'b0;
    inst_hi  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // ADD with stray acks in ID/EX, one IF wait
    add("add_if",  Add, 1, 0, 0, 8'b1001_0000, 3'd0, 0, 2'b00);
    add("add_id",  Add, 1, 1, 0, 8'b0000_0000, 3'd1, 0, 2'b00);
    add("add_ex",  Add, 0, 1, 0, 8'b0000_0000, 3'd2, 0, 2'b00);
    add("add_wb",  Add, 0, 0, 0, 8'b0000_1110, 3'd4, 0, 2'b00);
    add("if_wait", Add, 0, 0, 0, 8'b1000_0000, 3'd0, 0, 2'b00);
    // LD_W, dmem_ack after 3 wait cycles, halt_req pulses mid-instruction
    add("ld_if",   Ldw, 1, 0, 0, 8'b1001_0000, 3'd0, 0, 2'b00);
    add("ld_id",   Ldw, 0, 0, 1, 8'b0000_0000, 3'd1, 0, 2'b00);
    add("ld_ex",   Ldw, 0, 0, 0, 8'b0000_0000, 3'd2, 0, 2'b00);
    add("ld_mem0", Ldw, 0, 0, 0, 8'b0100_0000, 3'd3, 0, 2'b00);
    add("ld_mem1", Ldw, 0, 0, 1, 8'b0100_0000, 3'd3, 0, 2'b00);
    add("ld_mem2", Ldw, 0, 0, 0, 8'b0100_0000, 3'd3, 0, 2'b00);
    add("ld_mem3", Ldw, 0, 1, 0, 8'b0100_0000, 3'd3, 0, 2'b00);
    add("ld_wb",   Ldw, 0, 0, 0, 8'b0000_1110, 3'd4, 0, 2'b00);
    // ST_W, immediate ack
    add("st_if",   Stw, 1, 0, 0, 8'b1001_0000, 3'd0, 0, 2'b00);
    add("st_id",   Stw, 0, 0, 0, 8'b0000_0000, 3'd1, 0, 2'b00);
    add("st_ex",   Stw, 0, 0, 0, 8'b0000_0000, 3'd2, 0, 2'b00);
    add("st_mem",  Stw, 0, 1, 0, 8'b0110_1010, 3'd3, 0, 2'b00);
    // BEQ with halt_req at completion, then release
    add("bq_if",   Beq, 1, 0, 0, 8'b1001_0000, 3'd0, 0, 2'b00);
    add("bq_id",   Beq, 0, 0, 0, 8'b0000_0000, 3'd1, 0, 2'b00);
    add("bq_ex",   Beq, 0, 0, 1, 8'b0000_1010, 3'd2, 0, 2'b00);
    add("hlt0",    Beq, 1, 0, 1, 8'b0000_0001, 3'd5, 0, 2'b00);
    add("hlt1",    Beq, 0, 0, 0, 8'b0000_0001, 3'd5, 0, 2'b00);
    // IF ack arriving exactly at the timeout boundary wins
    add("tw0",     Beq, 0, 0, 0, 8'b1000_0000, 3'd0, 0, 2'b00);
    add("tw1",     Beq, 0, 0, 0, 8'b1000_0000, 3'd0, 0, 2'b00);
    add("tw2",     Beq, 0, 0, 0, 8'b1000_0000, 3'd0, 0, 2'b00);
    add("tw3",     Beq, 0, 0, 0, 8'b1000_0000, 3'd0, 0, 2'b00);
    add("tw_ack",  Beq, 1, 0, 0, 8'b1001_0000, 3'd0, 0, 2'b00);
    add("tb_id",   Beq, 0, 0, 0, 8'b0000_0000, 3'd1, 0, 2'b00);
    add("tb_ex",   Beq, 0, 0, 0, 8'b0000_1010, 3'd2, 0, 2'b00);
    // IF timeout: no ack at the boundary
    add("tf0",     Beq, 0, 0, 0, 8'b1000_0000, 3'd0, 0, 2'b00);
    add("tf1",     Beq, 0, 0, 0, 8'b1000_0000, 3'd0, 0, 2'b00);
    add("tf2",     Beq, 0, 0, 0, 8'b1000_0000, 3'd0, 0, 2'b00);
    add("tf3",     Beq, 0, 0, 0, 8'b1000_0000, 3'd0, 0, 2'b00);
    add("tf4",     Beq, 0, 0, 0, 8'b1000_0000, 3'd0, 0, 2'b00);
    add("err0",    Beq, 1, 1, 0, 8'b0000_0000, 3'd7, 1, 2'b01);
    add("err1",    Beq, 1, 1, 1, 8'b0000_0000, 3'd7, 1, 2'b01);

    // Outputs quiet while reset is held, even with an ack present
    rst_n    = 1'b0;
    inst_hi  = Add;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    halt_req = 1'b0;
    #12;
    check("in_reset", ev(8'b0000_0000, 3'd0, 0, 2'b00, 4'd0));
    do_reset();

    foreach (tbl[i]) step(tbl[i].name, tbl[i].inst, tbl[i].ia, tbl[i].da, tbl[i].hr, tbl[i].exp);

    // Illegal opcode
    do_reset();
    step("ill_if",  Ill, 1, 0, 0, ev(8'b1001_0000, 3'd0, 0, 2'b00, 4'd0));
    step("ill_id",  Ill, 0, 0, 0, ev(8'b0000_0000, 3'd1, 0, 2'b00, 4'd0));
    step("ill_ex",  Ill, 0, 0, 0, ev(8'b0000_0000, 3'd2, 0, 2'b00, 4'd0));
    step("ill_err", Ill, 1, 1, 0, ev(8'b0000_0000, 3'd7, 1, 2'b11, 4'd0));

    // Memory opcode with a reserved func3
    do_reset();
    step("ill2_if",  Ill2, 1, 0, 0, ev(8'b1001_0000, 3'd0, 0, 2'b00, 4'd0));
    step("ill2_id",  Ill2, 0, 0, 0, ev(8'b0000_0000, 3'd1, 0, 2'b00, 4'd0));
    step("ill2_ex",  Ill2, 0, 0, 0, ev(8'b0000_0000, 3'd2, 0, 2'b00, 4'd0));
    step("ill2_err", Ill2, 0, 0, 0, ev(8'b0000_0000, 3'd7, 1, 2'b11, 4'd0));

    // Data memory timeout
    do_reset();
    step("dto_if", Ldw, 1, 0, 0, ev(8'b1001_0000, 3'd0, 0, 2'b00, 4'd0));
    step("dto_id", Ldw, 0, 0, 0, ev(8'b0000_0000, 3'd1, 0, 2'b00, 4'd0));
    step("dto_ex", Ldw, 0, 0, 0, ev(8'b0000_0000, 3'd2, 0, 2'b00, 4'd0));
    for (int i = 0; i < 5; i++)
      step("dto_mem", Ldw, 0, 0, 0, ev(8'b0100_0000, 3'd3, 0, 2'b00, 4'd0));
    step("dto_err", Ldw, 0, 1, 0, ev(8'b0000_0000, 3'd7, 1, 2'b10, 4'd0));

    // Reset asserted mid-MEM after one retired instruction
    do_reset();
    step("r_add_if", Add, 1, 0, 0, ev(8'b1001_0000, 3'd0, 0, 2'b00, 4'd0));
    step("r_add_id", Add, 0, 0, 0, ev(8'b0000_0000, 3'd1, 0, 2'b00, 4'd0));
    step("r_add_ex", Add, 0, 0, 0, ev(8'b0000_0000, 3'd2, 0, 2'b00, 4'd0));
    step("r_add_wb", Add, 0, 0, 0, ev(8'b0000_1110, 3'd4, 0, 2'b00, 4'd0));
    step("r_ld_if",  Ldw, 1, 0, 0, ev(8'b1001_0000, 3'd0, 0, 2'b00, 4'd1));
    step("r_ld_id",  Ldw, 0, 0, 0, ev(8'b0000_0000, 3'd1, 0, 2'b00, 4'd1));
    step("r_ld_ex",  Ldw, 0, 0, 0, ev(8'b0000_0000, 3'd2, 0, 2'b00, 4'd1));
    step("r_ld_mem", Ldw, 0, 0, 0, ev(8'b0100_0000, 3'd3, 0, 2'b00, 4'd1));
    #1;
    check("pre_rst_mem", ev(8'b0100_0000, 3'd3, 0, 2'b00, 4'd1));
    rst_n = 1'b0;
    #1;
    check("mid_mem_rst", ev(8'b0000_0000, 3'd0, 0, 2'b00, 4'd0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post_rst_if", Add, 0, 0, 0, ev(8'b1000_0000, 3'd0, 0, 2'b00, 4'd0));

    // Retire counter wrap over 16 branches
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] c;
      c = i[3:0];
      step("wrap_if", Beq, 1, 0, 0, ev(8'b1001_0000, 3'd0, 0, 2'b00, c));
      step("wrap_id", Beq, 0, 0, 0, ev(8'b0000_0000, 3'd1, 0, 2'b00, c));
      step("wrap_ex", Beq, 0, 0, 0, ev(8'b0000_1010, 3'd2, 0, 2'b00, c));
    end
    step("wrap_done", Beq, 0, 0, 0, ev(8'b1000_0000, 3'd0, 0, 2'b00, 4'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
